router_pkt_tx: RTL

//  Source-side packet transmitter for the 1x3 router: buffers one payload, then drives the router input
//  (pkt_valid, data_in) with header, payload and parity bytes, stalling on router busy. Sits between a

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_tx_buf.sv | 30 +++
 rtl/router_pkt_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants, header layout and transmitter state encodings for the 1x3 router source side.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: {length[5:0], dest_addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB  = ADDR_W;
  localparam int HDR_LEN_MSB  = ADDR_W + LEN_W - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } tx_state_e;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                             input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    h[HDR_ADDR_LSB +: ADDR_W]  = addr;
    return h;
  endfunction
endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: DEPTH x 8 register file filled sequentially, combinational read by index.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [LEN_W-1:0] count,
  output logic [7:0]       rd_data
);
  logic [7:0] mem [DEPTH];

  // wr_en arrives already qualified by the owner (IDLE and not full)
  always_ff @(posedge clk) begin
    if (wr_en) mem[count] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      count <= '0;
    else if (clr)   count <= '0;
    else if (wr_en) count <= count + LEN_W'(1);
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/router_pkt_tx.sv
// Router source transmitter: buffers a payload, then streams header, payload and parity with busy stalls.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DEPTH = 63,
  parameter int IFG   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              send,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              tx_idle,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);
  // Stream handshake: the byte on data_out (pkt_valid=1 for header/payload, 0 for parity)
  // is taken on every rising edge where busy==0; while busy==1 every output holds.
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [7:0]       GAP_LAST = 8'((IFG > 1) ? IFG - 2 : 0);

  tx_state_e        state, state_n;
  logic [LEN_W-1:0] idx, idx_n, count, rd_idx, len_next;
  logic [7:0]       parity, parity_n, data_n, rd_data, gap_cnt, gap_n;
  logic             pv_n, done_n, err_n, wr_take, clr;

  router_tx_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_take),
    .wr_data (wr_data),
    .clr     (clr),
    .rd_idx  (rd_idx),
    .count   (count),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    parity_n = parity;
    data_n   = data_out;
    pv_n     = pkt_valid;
    gap_n    = gap_cnt;
    done_n   = 1'b0;
    err_n    = 1'b0;
    clr      = 1'b0;
    wr_take  = (state == S_IDLE) && wr_en && (count < DEPTH_L);
    // A write in the same cycle as send is counted in the header length
    len_next = count + LEN_W'(wr_take);
    rd_idx   = (state == S_PAYLOAD) ? idx + LEN_W'(1) : '0;
    if (wr_en && !wr_take) err_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (send) begin
          if (dest_addr == ADDR_INVALID || len_next == '0) begin
            err_n = 1'b1;
          end else begin
            state_n  = S_HEADER;
            data_n   = make_header(len_next, dest_addr);
            parity_n = make_header(len_next, dest_addr);
            pv_n     = 1'b1;
            idx_n    = '0;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_n = S_PAYLOAD;
          data_n  = rd_data;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          parity_n = parity ^ data_out;
          if (idx == count - LEN_W'(1)) begin
            state_n = S_PARITY;
            pv_n    = 1'b0;
            data_n  = parity ^ data_out;
          end else begin
            idx_n  = idx + LEN_W'(1);
            data_n = rd_data;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          done_n  = 1'b1;
          clr     = 1'b1;
          data_n  = '0;
          gap_n   = '0;
          state_n = (IFG > 1) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        // The first IDLE cycle is also idle on the wire, so GAP covers IFG-1 cycles
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
        else                     gap_n   = gap_cnt + 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      idx       <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tx_idle   <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      parity    <= parity_n;
      gap_cnt   <= gap_n;
      data_out  <= data_n;
      pkt_valid <= pv_n;
      done      <= done_n;
      err       <= err_n;
      tx_idle   <= (state_n == S_IDLE);
    end
  end

  assign state_dbg = state;
endmodule
